// File: rtl/misr_sig_checker_if.sv
// Handshake/result bundle for misr_sig_checker.
// EXPECT_MASK exists only when MISR_SIG_CHECK_MASK_EN is defined.
interface misr_sig_checker_if #(
  parameter int unsigned LEN_W = 16
);
  logic             START;
  logic [LEN_W-1:0] LEN;
  logic [31:0]      EXPECT;
`ifdef MISR_SIG_CHECK_MASK_EN
  logic [31:0]      EXPECT_MASK;
`endif
  logic             DATA_VALID;
  logic [31:0]      DATA;
  logic             DATA_READY;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [31:0]      SIGNATURE;

  modport master (
    output START, LEN, EXPECT,
`ifdef MISR_SIG_CHECK_MASK_EN
    output EXPECT_MASK,
`endif
    output DATA_VALID, DATA,
    input  DATA_READY, BUSY, DONE, PASS, SIGNATURE
  );

  modport slave (
    input  START, LEN, EXPECT,
`ifdef MISR_SIG_CHECK_MASK_EN
    input  EXPECT_MASK,
`endif
    input  DATA_VALID, DATA,
    output DATA_READY, BUSY, DONE, PASS, SIGNATURE
  );
endinterface

// File: rtl/misr_sig_checker.sv
// Streaming MISR signature checker: compacts LEN words, compares against EXPECT.
// Optional MISR_SIG_CHECK_MASK_EN adds a latched don't-care mask to the compare.
module misr_sig_checker #(
  parameter logic [31:0] POLY  = 32'h00008409,
  parameter logic [31:0] SEED  = 32'h00000000,
  parameter int unsigned LEN_W = 16
) (
  input logic               CLK,
  input logic               RESET,
  misr_sig_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    COMPACT,
    COMPARE,
    REPORT
  } state_t;

  state_t           state;
  logic [31:0]      sig;
  logic [LEN_W-1:0] cnt;
  logic [31:0]      exp_q;
`ifdef MISR_SIG_CHECK_MASK_EN
  logic [31:0]      mask_q;
`endif
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [31:0]      sig_next;
  logic             sig_match;
  logic             beat;

  always_comb begin
    sig_next = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : '0) ^ bus.DATA;
  end

  always_comb begin
`ifdef MISR_SIG_CHECK_MASK_EN
    sig_match = (((sig ^ exp_q) & mask_q) == '0);
`else
    sig_match = (sig == exp_q);
`endif
  end

  assign beat = bus.DATA_VALID & ready_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      sig     <= SEED;
      cnt     <= '0;
      exp_q   <= '0;
`ifdef MISR_SIG_CHECK_MASK_EN
      mask_q  <= '0;
`endif
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            sig    <= SEED;
            cnt    <= bus.LEN;
            exp_q  <= bus.EXPECT;
`ifdef MISR_SIG_CHECK_MASK_EN
            mask_q <= bus.EXPECT_MASK;
`endif
            pass_q <= 1'b0;
            busy_q <= 1'b1;
            // A zero-length check skips compaction and compares SEED directly.
            if (bus.LEN != '0) begin
              state   <= COMPACT;
              ready_q <= 1'b1;
            end else begin
              state   <= COMPARE;
            end
          end
        end

        COMPACT: begin
          if (beat) begin
            sig <= sig_next;
            cnt <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              state   <= COMPARE;
              ready_q <= 1'b0;
            end
          end
        end

        COMPARE: begin
          pass_q <= sig_match;
          done_q <= 1'b1;
          state  <= REPORT;
        end

        REPORT: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DATA_READY = ready_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.PASS       = pass_q;
  assign bus.SIGNATURE  = sig;

endmodule

// File: tb/tb_misr_sig_checker.sv
// Directed self-checking bench for misr_sig_checker.
module tb_misr_sig_checker;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] words [8];
  logic [31:0] sig_at [64];
  int          done_cyc;
  int          nbeats;
  int          ndone;
  int          rdy_cnt;
  logic [31:0] fin_sig;
  logic        fin_pass;
  logic        post_busy;
  logic        post_done;
`ifdef MISR_SIG_CHECK_MASK_EN
  logic [31:0] cur_mask = 32'hFFFFFFFF;
`endif

  misr_sig_checker_if #(.LEN_W(16)) bus ();

  misr_sig_checker #(
    .POLY (32'h00008409),
    .SEED (32'h00000000),
    .LEN_W(16)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Runs one check: START in cycle 0, DATA_VALID per vpat bit (c-1) for cycle c,
  // an extra START pulse in cycle spc, stops one cycle after DONE or at budget.
  task automatic run(input logic [15:0] len, input logic [31:0] expv,
                     input logic [15:0] vpat, input int spc, input int budget);
    done_cyc = -1;
    nbeats   = 0;
    ndone    = 0;
    rdy_cnt  = 0;
    fin_sig  = 'x;
    fin_pass = 1'bx;
    post_busy = 1'bx;
    post_done = 1'bx;
    bus.START      = 1'b1;
    bus.LEN        = len;
    bus.EXPECT     = expv;
`ifdef MISR_SIG_CHECK_MASK_EN
    bus.EXPECT_MASK = cur_mask;
`endif
    bus.DATA_VALID = 1'b0;
    bus.DATA       = '0;
    for (int c = 1; c < budget; c++) begin
      @(posedge CLK); #1;
      bus.START = (c == spc);
      if (c == spc) begin
        bus.LEN    = 16'd7;
        bus.EXPECT = 32'hFFFFFFFF;
      end
      bus.DATA_VALID = (c <= 16) ? vpat[c-1] : 1'b1;
      bus.DATA       = bus.DATA_VALID ? words[nbeats % 8] : 32'hDEADBEEF;
      @(negedge CLK);
      if (c < 64) sig_at[c] = bus.SIGNATURE;
      if (bus.DATA_READY) rdy_cnt++;
      if (bus.DATA_READY && bus.DATA_VALID) nbeats++;
      if (bus.DONE) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c;
          fin_sig  = bus.SIGNATURE;
          fin_pass = bus.PASS;
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        post_busy = bus.BUSY;
        post_done = bus.DONE;
        break;
      end
    end
    @(posedge CLK); #1;
    bus.START      = 1'b0;
    bus.DATA_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET          = 1'b1;
    bus.START      = 1'b1;
    bus.DATA_VALID = 1'b1;
    bus.LEN        = 16'd3;
    bus.EXPECT     = 32'h0;
    bus.DATA       = 32'hFFFFFFFF;
`ifdef MISR_SIG_CHECK_MASK_EN
    bus.EXPECT_MASK = 32'hFFFFFFFF;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({bus.DATA_READY, bus.BUSY, bus.DONE, bus.PASS, bus.SIGNATURE} !== 36'h0) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d: got rdy=%b busy=%b done=%b pass=%b sig=%h want 0/0/0/0/00000000",
                 i, bus.DATA_READY, bus.BUSY, bus.DONE, bus.PASS, bus.SIGNATURE);
      end
    end
    @(posedge CLK); #1;
    bus.START      = 1'b0;
    bus.DATA_VALID = 1'b0;
    RESET          = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_single_beat();
    words[0] = 32'h00000001;
    run(16'd1, 32'h00000001, 16'hFFFF, -1, 20);
    n_cmp++; if (done_cyc !== 3) begin n_err++; $display("FAIL single_done_cycle: got %0d want 3", done_cyc); end
    n_cmp++; if (fin_pass !== 1'b1) begin n_err++; $display("FAIL single_pass: got %b want 1", fin_pass); end
    n_cmp++; if (fin_sig !== 32'h00000001) begin n_err++; $display("FAIL single_sig: got %h want 00000001", fin_sig); end
    n_cmp++; if (rdy_cnt !== 1) begin n_err++; $display("FAIL single_ready_cycles: got %0d want 1", rdy_cnt); end
    n_cmp++; if (ndone !== 1 || post_done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse: got count=%0d next=%b want 1/0", ndone, post_done); end
    n_cmp++; if (post_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after: got %b want 0", post_busy); end
  endtask

  task automatic test_feedback();
    words[0] = 32'h80000000;
    words[1] = 32'h00000000;
    run(16'd2, 32'h00008409, 16'hFFFF, -1, 20);
    n_cmp++; if (done_cyc !== 4) begin n_err++; $display("FAIL fb_done_cycle: got %0d want 4", done_cyc); end
    n_cmp++; if (fin_sig !== 32'h00008409) begin n_err++; $display("FAIL fb_sig: got %h want 00008409", fin_sig); end
    n_cmp++; if (fin_pass !== 1'b1) begin n_err++; $display("FAIL fb_pass: got %b want 1", fin_pass); end
    n_cmp++; if (sig_at[2] !== 32'h80000000) begin n_err++; $display("FAIL fb_sig_mid: got %h want 80000000", sig_at[2]); end
  endtask

  task automatic test_mismatch();
    words[0] = 32'h80000000;
    words[1] = 32'h00000000;
    run(16'd2, 32'h00008408, 16'hFFFF, -1, 20);
    n_cmp++; if (fin_pass !== 1'b0) begin n_err++; $display("FAIL mismatch_pass: got %b want 0", fin_pass); end
    n_cmp++; if (fin_sig !== 32'h00008409) begin n_err++; $display("FAIL mismatch_sig: got %h want 00008409", fin_sig); end
    n_cmp++; if (done_cyc !== 4) begin n_err++; $display("FAIL mismatch_done_cycle: got %0d want 4", done_cyc); end
`ifdef MISR_SIG_CHECK_MASK_EN
    cur_mask = 32'hFFFFFFFE;
    run(16'd2, 32'h00008408, 16'hFFFF, -1, 20);
    n_cmp++; if (fin_pass !== 1'b1) begin n_err++; $display("FAIL masked_pass: got %b want 1", fin_pass); end
    cur_mask = 32'hFFFFFFFF;
`endif
  endtask

  task automatic test_gaps();
    words[0] = 32'h00000003;
    words[1] = 32'h40000000;
    words[2] = 32'h00000005;
    run(16'd3, 32'h80000009, 16'h0029, 2, 30);
    n_cmp++; if (nbeats !== 3) begin n_err++; $display("FAIL gaps_beats: got %0d want 3", nbeats); end
    n_cmp++; if (done_cyc !== 8) begin n_err++; $display("FAIL gaps_done_cycle: got %0d want 8", done_cyc); end
    n_cmp++; if (fin_sig !== 32'h80000009) begin n_err++; $display("FAIL gaps_sig: got %h want 80000009", fin_sig); end
    n_cmp++; if (fin_pass !== 1'b1) begin n_err++; $display("FAIL gaps_pass: got %b want 1", fin_pass); end
    n_cmp++; if (sig_at[2] !== 32'h3 || sig_at[3] !== 32'h3) begin n_err++; $display("FAIL gaps_hold: got %h/%h want 00000003/00000003", sig_at[2], sig_at[3]); end
    n_cmp++; if (sig_at[5] !== 32'h40000006) begin n_err++; $display("FAIL gaps_sig_mid: got %h want 40000006", sig_at[5]); end
    n_cmp++; if (rdy_cnt !== 6) begin n_err++; $display("FAIL gaps_ready_cycles: got %0d want 6", rdy_cnt); end
  endtask

  task automatic test_len_zero();
    run(16'd0, 32'h00000000, 16'hFFFF, -1, 20);
    n_cmp++; if (done_cyc !== 2) begin n_err++; $display("FAIL len0_done_cycle: got %0d want 2", done_cyc); end
    n_cmp++; if (fin_pass !== 1'b1) begin n_err++; $display("FAIL len0_pass: got %b want 1", fin_pass); end
    n_cmp++; if (fin_sig !== 32'h0) begin n_err++; $display("FAIL len0_sig: got %h want 00000000", fin_sig); end
    n_cmp++; if (rdy_cnt !== 0) begin n_err++; $display("FAIL len0_ready: got %0d want 0", rdy_cnt); end
  endtask

  task automatic test_back_to_back();
    bus.START = 1'b1; bus.LEN = 16'd1; bus.EXPECT = 32'h00000001;
    bus.DATA_VALID = 1'b0;
`ifdef MISR_SIG_CHECK_MASK_EN
    bus.EXPECT_MASK = 32'hFFFFFFFF;
`endif
    @(posedge CLK); #1;
    bus.START = 1'b0; bus.DATA_VALID = 1'b1; bus.DATA = 32'h00000001;
    @(posedge CLK); #1;
    bus.DATA_VALID = 1'b0;
    @(posedge CLK); #1;
    // cycle 3: DONE; a START here must be ignored
    bus.START = 1'b1; bus.LEN = 16'd0; bus.EXPECT = 32'hFFFFFFFF;
    @(negedge CLK);
    n_cmp++; if (bus.DONE !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", bus.DONE); end
    @(posedge CLK); #1;
    bus.START = 1'b0;
    @(negedge CLK);
    n_cmp++; if (bus.BUSY !== 1'b0 || bus.PASS !== 1'b1) begin n_err++; $display("FAIL b2b_start_in_done: got busy=%b pass=%b want 0/1", bus.BUSY, bus.PASS); end
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.LEN = 16'd1; bus.EXPECT = 32'h00000010;
    @(posedge CLK); #1;
    bus.START = 1'b0; bus.DATA_VALID = 1'b1; bus.DATA = 32'h00000010;
    @(negedge CLK);
    n_cmp++; if ({bus.BUSY, bus.DATA_READY, bus.PASS} !== 3'b110 || bus.SIGNATURE !== 32'h0) begin
      n_err++; $display("FAIL b2b_restart: got busy=%b rdy=%b pass=%b sig=%h want 1/1/0/00000000", bus.BUSY, bus.DATA_READY, bus.PASS, bus.SIGNATURE);
    end
    @(posedge CLK); #1;
    bus.DATA_VALID = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_cmp++; if (bus.DONE !== 1'b1 || bus.PASS !== 1'b1 || bus.SIGNATURE !== 32'h10) begin
      n_err++; $display("FAIL b2b_second_result: got done=%b pass=%b sig=%h want 1/1/00000010", bus.DONE, bus.PASS, bus.SIGNATURE);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_abort();
    int dcount;
    bus.START = 1'b1; bus.LEN = 16'd5; bus.EXPECT = 32'h0; bus.DATA_VALID = 1'b0;
    @(posedge CLK); #1;
    bus.START = 1'b0; bus.DATA_VALID = 1'b1; bus.DATA = 32'h00000001;
    @(posedge CLK); #1;
    bus.DATA = 32'h00000004;
    @(posedge CLK); #1;
    n_cmp++; if (bus.SIGNATURE !== 32'h6 || bus.BUSY !== 1'b1) begin n_err++; $display("FAIL abort_pre: got sig=%h busy=%b want 00000006/1", bus.SIGNATURE, bus.BUSY); end
    RESET = 1'b1;
    #1;
    n_cmp++; if ({bus.BUSY, bus.DATA_READY, bus.DONE, bus.PASS} !== 4'b0 || bus.SIGNATURE !== 32'h0) begin
      n_err++; $display("FAIL abort_reset: got busy=%b rdy=%b done=%b pass=%b sig=%h want 0/0/0/0/00000000",
                        bus.BUSY, bus.DATA_READY, bus.DONE, bus.PASS, bus.SIGNATURE);
    end
    bus.DATA_VALID = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (bus.DONE) dcount++;
    end
    n_cmp++; if (dcount !== 0 || bus.BUSY !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got done_count=%0d busy=%b want 0/0", dcount, bus.BUSY); end
  endtask

  initial begin
    bus.START = 1'b0;
    bus.LEN = '0;
    bus.EXPECT = '0;
    bus.DATA_VALID = 1'b0;
    bus.DATA = '0;
`ifdef MISR_SIG_CHECK_MASK_EN
    bus.EXPECT_MASK = '1;
`endif
    for (int i = 0; i < 8; i++) words[i] = '0;
    test_reset();
    test_single_beat();
    test_feedback();
    test_mismatch();
    test_gaps();
    test_len_zero();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
